// File: rtl/timer_irq.sv
// Programmable down-counting timer with a single interrupt output on the CPU peripheral bus.
// Latency: register writes take effect on the next rising edge; dout and irq are combinational.
// Backpressure: none; the bus is always accepted and the timer never stalls the bus.
module timer_irq #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  // Architectural state
  state_e             state_q, state_d;
  logic               ctrl_en_q, ctrl_en_d;
  logic [1:0]         ctrl_mode_q, ctrl_mode_d;
  logic               ctrl_im_q, ctrl_im_d;
  logic [CNT_W-1:0]   preset_q, preset_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               flag_q, flag_d;

  // Bus decode
  logic wr_ctrl;
  logic wr_preset;

  // FSM side effects feeding the register next-state logic
  logic flag_set;
  logic flag_auto_clr;
  logic hw_en_clr;
  logic mode_reload;

  // Zero-extended views for readback
  logic [31:0] preset_ext;
  logic [31:0] count_ext;

  assign wr_ctrl     = we && (addr == A_CTRL);
  assign wr_preset   = we && (addr == A_PRESET);
  // Modes 1x fall back to one-shot behaviour.
  assign mode_reload = (ctrl_mode_q == MODE_RELOAD);

  // FSM next-state, counter next value and FSM-driven side effects
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    flag_set      = 1'b0;
    flag_auto_clr = 1'b0;
    hw_en_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_en_q) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // PRESET is sampled only here, so writes during counting wait for the next reload.
        count_d = preset_q;
        state_d = ctrl_en_q ? ST_CNT : ST_IDLE;
      end
      ST_CNT: begin
        if (!ctrl_en_q) begin
          state_d = ST_IDLE;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          // Expiry at 1 (or 0 when PRESET was 0): never wraps below zero.
          count_d  = '0;
          state_d  = ST_INT;
          flag_set = 1'b1;
        end
      end
      ST_INT: begin
        if (mode_reload) begin
          flag_auto_clr = 1'b1;
          state_d       = ST_LOAD;
        end else begin
          hw_en_clr = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Software-visible register next values; a bus write to CTRL beats the hardware EN clear
  always_comb begin
    ctrl_en_d   = ctrl_en_q;
    ctrl_mode_d = ctrl_mode_q;
    ctrl_im_d   = ctrl_im_q;
    preset_d    = preset_q;
    if (wr_ctrl) begin
      ctrl_en_d   = din[0];
      ctrl_mode_d = din[2:1];
      ctrl_im_d   = din[3];
    end else if (hw_en_clr) begin
      ctrl_en_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = din[CNT_W-1:0];
    end
  end

  // Interrupt flag: expiry set has priority over any clear in the same cycle
  always_comb begin
    flag_d = flag_q;
    if (wr_ctrl || wr_preset || flag_auto_clr) begin
      flag_d = 1'b0;
    end
    if (flag_set) begin
      flag_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ctrl_en_q   <= 1'b0;
      ctrl_mode_q <= 2'b00;
      ctrl_im_q   <= 1'b0;
      preset_q    <= '0;
      count_q     <= '0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_en_q   <= ctrl_en_d;
      ctrl_mode_q <= ctrl_mode_d;
      ctrl_im_q   <= ctrl_im_d;
      preset_q    <= preset_d;
      count_q     <= count_d;
      flag_q      <= flag_d;
    end
  end

  // Zero-extend PRESET/COUNT to the 32-bit bus for any CNT_W
  always_comb begin
    preset_ext              = '0;
    count_ext               = '0;
    preset_ext[CNT_W-1:0]   = preset_q;
    count_ext[CNT_W-1:0]    = count_q;
  end

  // Combinational readback mux
  always_comb begin
    dout = '0;
    case (addr)
      A_CTRL:   dout = {28'd0, ctrl_im_q, ctrl_mode_q, ctrl_en_q};
      A_PRESET: dout = preset_ext;
      A_COUNT:  dout = count_ext;
      default:  dout = '0;
    endcase
  end

  // Masked interrupt; drops immediately with the asynchronous reset of its sources
  assign irq = ctrl_im_q & flag_q;

endmodule

// File: tb/tb_timer_irq.sv
// Self-checking bench for timer_irq: directed table, hand-written corner sequences, random traffic.
// Each tick drives inputs just after a rising edge and samples outputs on the falling edge.
// A behavioural model tracks expected CTRL/PRESET/COUNT/flag from the register-level rules.
module tb_timer_irq;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] s_dout;
  logic        s_irq;

  timer_irq #(.CNT_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_FIRE = 3;

  int          m_ph;
  bit          m_en;
  bit          m_im;
  bit [1:0]    m_mode;
  int unsigned m_preset;
  int unsigned m_count;
  bit          m_flag;

  function automatic void model_reset();
    m_ph = PH_IDLE; m_en = 0; m_im = 0; m_mode = 2'b00;
    m_preset = 0; m_count = 0; m_flag = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_step(input logic w, input logic [1:0] a, input logic [31:0] d);
    bit wr_c, wr_p, fire, auto_clr, hw_clr;
    int nph;
    int unsigned ncount;
    wr_c = w && (a == 2'd0);
    wr_p = w && (a == 2'd1);
    fire = 0; auto_clr = 0; hw_clr = 0;
    nph = m_ph;
    ncount = m_count;
    if (m_ph == PH_IDLE) begin
      if (m_en) nph = PH_LOAD;
    end else if (m_ph == PH_LOAD) begin
      ncount = m_preset;
      nph = m_en ? PH_RUN : PH_IDLE;
    end else if (m_ph == PH_RUN) begin
      if (!m_en) nph = PH_IDLE;
      else if (m_count > 1) ncount = m_count - 1;
      else begin ncount = 0; nph = PH_FIRE; fire = 1; end
    end else begin
      if (m_mode == 2'b01) begin auto_clr = 1; nph = PH_LOAD; end
      else begin hw_clr = 1; nph = PH_IDLE; end
    end
    if (fire) m_flag = 1;
    else if (auto_clr || wr_c || wr_p) m_flag = 0;
    if (wr_c) begin m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; end
    else if (hw_clr) m_en = 0;
    if (wr_p) m_preset = d;
    m_ph = nph;
    m_count = ncount;
  endfunction

  // ---------------- checking helpers ----------------
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // One bus cycle: drive, sample on falling edge against the model, then advance on the rising edge.
  task automatic tick(input logic w, input logic [1:0] a, input logic [31:0] d);
    we = w; addr = a; din = d;
    @(negedge clk);
    s_dout = dout;
    s_irq  = irq;
    chk("model_dout", s_dout, model_read(a));
    chk("model_irq", {31'd0, s_irq}, {31'd0, m_im & m_flag});
    @(posedge clk);
    model_step(w, a, d);
    #1;
    we = 1'b0;
  endtask

  // Asynchronous reset between clock edges; outputs must clear without an edge.
  task automatic do_async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    chk({tag, "_irq_async"}, {31'd0, irq}, 32'd0);
    chk({tag, "_dout_async"}, dout, 32'd0);
    for (int a = 0; a < 3; a++) begin
      addr = 2'(a);
      #1;
      chk({tag, "_dout_in_reset"}, dout, 32'd0);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_step(1'b0, addr, 32'd0);
    #1;
    for (int a = 0; a < 3; a++) begin
      tick(1'b0, 2'(a), 32'd0);
      chk({tag, "_read_after_release"}, s_dout, 32'd0);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[16];
  int   pulse_at[10];
  int   np;
  int   r;
  logic [31:0] rd;

  initial begin
    // One-shot sequence: PRESET=5, CTRL=0x9, held irq, cleared by CTRL=0x8.
    tbl[0]  = '{1'b1, 2'd1, 32'd5, 32'd0, 1'b0};
    tbl[1]  = '{1'b1, 2'd0, 32'd9, 32'd0, 1'b0};
    tbl[2]  = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b0};
    tbl[3]  = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b0};
    tbl[4]  = '{1'b0, 2'd2, 32'd0, 32'd5, 1'b0};
    tbl[5]  = '{1'b0, 2'd2, 32'd0, 32'd4, 1'b0};
    tbl[6]  = '{1'b0, 2'd2, 32'd0, 32'd3, 1'b0};
    tbl[7]  = '{1'b0, 2'd2, 32'd0, 32'd2, 1'b0};
    tbl[8]  = '{1'b0, 2'd2, 32'd0, 32'd1, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 32'd0, 32'd9, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 32'd0, 32'd8, 1'b1};
    tbl[11] = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b1};
    tbl[12] = '{1'b1, 2'd0, 32'd8, 32'd8, 1'b1};
    tbl[13] = '{1'b0, 2'd0, 32'd0, 32'd8, 1'b0};
    tbl[14] = '{1'b0, 2'd1, 32'd0, 32'd5, 1'b0};
    tbl[15] = '{1'b0, 2'd3, 32'd0, 32'd0, 1'b0};

    reset = 1'b0; we = 1'b0; addr = 2'd0; din = 32'd0;
    model_reset();
    #2;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      chk("reset_dout", dout, 32'd0);
    end
    chk("reset_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_step(1'b0, addr, 32'd0);
    #1;

    // Directed table
    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].we, tbl[i].addr, tbl[i].din);
      chk($sformatf("tbl%0d_dout", i), s_dout, tbl[i].exp_dout);
      chk($sformatf("tbl%0d_irq", i), {31'd0, s_irq}, {31'd0, tbl[i].exp_irq});
    end

    // IM=0: expiry never raises irq, COUNT ends at 0, EN cleared.
    tick(1'b1, 2'd1, 32'd4);
    tick(1'b1, 2'd0, 32'd1);
    for (int j = 1; j <= 10; j++) begin
      tick(1'b0, 2'd2, 32'd0);
      chk("masked_irq", {31'd0, s_irq}, 32'd0);
    end
    chk("masked_count", s_dout, 32'd0);
    tick(1'b0, 2'd0, 32'd0);
    chk("masked_ctrl", s_dout, 32'd0);

    // Auto-reload: one-cycle pulse every PRESET+2 = 5 cycles.
    tick(1'b1, 2'd1, 32'd3);
    tick(1'b1, 2'd0, 32'hB);
    for (int k = 0; k < 10; k++) pulse_at[k] = -1;
    np = 0;
    for (int j = 1; j <= 60; j++) begin
      tick(1'b0, 2'd0, 32'd0);
      if (s_irq && np < 10) begin
        pulse_at[np] = j;
        np++;
      end
    end
    for (int k = 0; k < 10; k++) chk($sformatf("reload_pulse%0d", k), 32'(pulse_at[k]), 32'(6 + 5 * k));
    chk("reload_ctrl_kept", s_dout, 32'hB);
    tick(1'b1, 2'd0, 32'd0);
    for (int j = 0; j < 3; j++) tick(1'b0, 2'd0, 32'd0);

    // Disable mid-count freezes COUNT; re-enable reloads from PRESET.
    tick(1'b1, 2'd1, 32'd20);
    tick(1'b1, 2'd0, 32'd9);
    for (int j = 1; j <= 9; j++) begin
      tick(1'b0, 2'd2, 32'd0);
      if (j >= 3) chk("run_count", s_dout, 32'(23 - j));
    end
    tick(1'b1, 2'd0, 32'd8);
    for (int j = 0; j < 5; j++) begin
      tick(1'b0, 2'd2, 32'd0);
      chk("frozen_count", s_dout, 32'd12);
    end
    tick(1'b1, 2'd0, 32'd9);
    for (int j = 1; j <= 23; j++) begin
      tick(1'b0, 2'd2, 32'd0);
      chk($sformatf("reen_irq_j%0d", j), {31'd0, s_irq}, {31'd0, (j == 23)});
      if (j == 2) chk("reen_before_load", s_dout, 32'd12);
      if (j == 3) chk("reen_reloaded", s_dout, 32'd20);
    end

    // PRESET=0, CTRL write beating the EN clear, PRESET write racing expiry.
    tick(1'b1, 2'd1, 32'd0);
    tick(1'b1, 2'd0, 32'd9);
    for (int j = 1; j <= 3; j++) begin
      tick(1'b0, 2'd0, 32'd0);
      chk("p0_irq_low", {31'd0, s_irq}, 32'd0);
    end
    tick(1'b1, 2'd0, 32'd9);
    chk("p0_irq_high", {31'd0, s_irq}, 32'd1);
    tick(1'b0, 2'd0, 32'd0);
    chk("ctrl_write_wins", s_dout, 32'd9);
    chk("ctrl_write_clears", {31'd0, s_irq}, 32'd0);
    tick(1'b0, 2'd2, 32'd0);
    tick(1'b1, 2'd1, 32'd0);
    chk("race_pre_irq", {31'd0, s_irq}, 32'd0);
    tick(1'b0, 2'd0, 32'd0);
    chk("race_set_wins", {31'd0, s_irq}, 32'd1);
    tick(1'b0, 2'd0, 32'd0);
    chk("race_held", {31'd0, s_irq}, 32'd1);
    chk("race_en_cleared", s_dout, 32'd8);

    // Async reset while irq is held
    addr = 2'd2;
    do_async_reset("rst_irq");

    // Async reset mid-count with a large PRESET
    tick(1'b1, 2'd1, 32'd100);
    tick(1'b1, 2'd0, 32'd9);
    for (int j = 1; j <= 10; j++) tick(1'b0, 2'd2, 32'd0);
    chk("midcount_value", s_dout, 32'd93);
    addr = 2'd2;
    do_async_reset("rst_cnt");

    // Random bus traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 6) begin
        rd = $urandom;
        rd[0] = ($urandom_range(0, 9) < 7);
        tick(1'b1, 2'd0, rd);
      end else if (r < 12) begin
        rd = 32'($urandom_range(0, 7));
        tick(1'b1, 2'd1, rd);
      end else if (r < 14) begin
        tick(1'b1, 2'd2, $urandom);
      end else if (r < 15) begin
        tick(1'b1, 2'd3, $urandom);
      end else begin
        tick(1'b0, 2'($urandom_range(0, 3)), $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
